// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial unsigned adder/subtractor. A single full-adder /
//               full-subtractor cell and a carry/borrow flop process WIDTH-bit
//               operands LSB first, one bit per clock, behind a
//               start/busy/done handshake. Result and carry-out are
//               registered and held until the next completion.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous reset, active-high
//               start   - request, sampled only in IDLE or DONE
//               mode    - 0 = add (a+b), 1 = subtract (a-b), latched on start
//               a, b    - WIDTH-bit operands, latched on start
//               busy    - high while bits are being processed
//               done    - one-cycle pulse, result/cout valid
//               result  - sum or difference (modulo 2^WIDTH)
//               cout    - add: carry-out, sub: borrow-out (a < b)
// Config      : SERIAL_ADDSUB_SAT_EN - when defined, the result saturates on
//               completion (add overflow -> all ones, sub borrow -> zero);
//               cout still reports the raw carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  // Operands are shifted right each bit, so the cell always looks at bit 0.
  logic             ai;
  logic             bi;
  logic             sum_bit;
  logic             carry_nx;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] res_final;

  assign ai      = a_q[0];
  assign bi      = b_q[0];
  // Sum and difference bits share the same XOR; only the carry/borrow differs.
  assign sum_bit = ai ^ bi ^ carry_q;
  assign carry_nx = mode_q ? ((~ai & bi) | (carry_q & ~(ai ^ bi)))
                           : (( ai & bi) | (carry_q &  (ai ^ bi)));
  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign sh_next = {sum_bit, sh_q[WIDTH-1:1]};

`ifdef SERIAL_ADDSUB_SAT_EN
  always_comb begin
    res_final = sh_next;
    if (carry_nx) begin
      res_final = mode_q ? '0 : '1;
    end
  end
`else
  assign res_final = sh_next;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = sh_next;
        carry_d = carry_nx;
        if (cnt_q == C_LAST_BIT) begin
          state_d  = ST_DONE;
          result_d = res_final;
          cout_d   = carry_nx;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub. Drives a WIDTH=8 and a
//               WIDTH=4 instance and compares against an arithmetic model of
//               a+b / a-b modulo 2^WIDTH (with optional saturation when
//               SERIAL_ADDSUB_SAT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       s8, m8, s4, m4;
  logic [7:0] a8, b8, r8;
  logic [3:0] a4, b4, r4;
  logic       busy8, done8, c8, busy4, done4, c4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .mode(m8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(r8), .cout(c8)
  );

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(s4), .mode(m4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(r4), .cout(c4)
  );

  // Reference: returns {cout, result} for a WIDTH-w operation.
  function automatic logic [8:0] model(input int w, input int a, input int b, input bit m);
    int mask = (1 << w) - 1;
    int res;
    bit c;
    if (m) begin
      res = (a - b) & mask;
      c   = (a < b);
    end else begin
      res = (a + b) & mask;
      c   = ((a + b) >> w) != 0;
    end
`ifdef SERIAL_ADDSUB_SAT_EN
    if (c) res = m ? 0 : mask;
`endif
    return {c, res[7:0]};
  endfunction

  task automatic set_in(input bit w4, input bit st, input logic [7:0] a, input logic [7:0] b, input bit m);
    if (w4) begin s4 = st; a4 = a[3:0]; b4 = b[3:0]; m4 = m; end
    else    begin s8 = st; a8 = a;      b8 = b;      m8 = m; end
  endtask

  function automatic logic get_busy(input bit w4); return w4 ? busy4 : busy8; endfunction
  function automatic logic get_done(input bit w4); return w4 ? done4 : done8; endfunction
  function automatic logic get_cout(input bit w4); return w4 ? c4 : c8; endfunction
  function automatic logic [7:0] get_res(input bit w4); return w4 ? {4'h0, r4} : r8; endfunction

  // Runs one operation from IDLE; operands are scrambled right after
  // acceptance so the DUT must rely on its latched copies.
  task automatic do_op(input bit w4, input logic [7:0] a, input logic [7:0] b, input bit m,
                       output logic [7:0] r, output logic c, output int nbusy,
                       output bit to, output logic done_after);
    set_in(w4, 1'b1, a, b, m);
    @(negedge clk);
    set_in(w4, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    nbusy = 0;
    to    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (get_done(w4)) begin to = 1'b0; break; end
      if (get_busy(w4)) nbusy++;
      @(negedge clk);
    end
    r = get_res(w4);
    c = get_cout(w4);
    @(negedge clk);
    done_after = get_done(w4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy8, done8, r8, c8} !== 11'h0) begin
      n_fail++; $display("FAIL reset8: busy/done/result/cout=%b/%b/%h/%b required 0/0/00/0", busy8, done8, r8, c8);
    end
    n_cmp++;
    if ({busy4, done4, r4, c4} !== 7'h0) begin
      n_fail++; $display("FAIL reset4: busy/done/result/cout=%b/%b/%h/%b required 0/0/0/0", busy4, done4, r4, c4);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] va [4] = '{8'h3C, 8'hFF, 8'h05, 8'h0A};
    logic [7:0] vb [4] = '{8'h05, 8'h01, 8'h0A, 8'h05};
    bit         vm [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] r; logic c, da; int nb; bit to; logic [8:0] ex;
    for (int i = 0; i < 4; i++) begin
      ex = model(8, int'(va[i]), int'(vb[i]), vm[i]);
      do_op(1'b0, va[i], vb[i], vm[i], r, c, nb, to, da);
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL directed_timeout[%0d]: no done within 40 cycles", i); end
      n_cmp++;
      if ({c, r} !== ex) begin
        n_fail++; $display("FAIL directed[%0d] %h %s %h: got cout=%b result=%h required cout=%b result=%h",
                           i, va[i], vm[i] ? "-" : "+", vb[i], c, r, ex[8], ex[7:0]);
      end
      n_cmp++;
      if (nb !== 8) begin n_fail++; $display("FAIL directed_busy[%0d]: busy cycles=%0d required 8", i, nb); end
      n_cmp++;
      if (da !== 1'b0) begin n_fail++; $display("FAIL directed_donepulse[%0d]: done after pulse=%b required 0", i, da); end
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, r; bit m; logic c, da; int nb; bit to; logic [8:0] ex;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
      if (i == 0) b = a;  // equal operands
      ex = model(8, int'(a), int'(b), m);
      do_op(1'b0, a, b, m, r, c, nb, to, da);
      n_cmp++;
      if (to || {c, r} !== ex) begin
        n_fail++; $display("FAIL random8 %h %s %h: got cout=%b result=%h timeout=%b required cout=%b result=%h",
                           a, m ? "-" : "+", b, c, r, to, ex[8], ex[7:0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [8:0] ex = model(8, 'h3C, 'h05, 1'b0);
    logic [8:0] got = '0;
    int ndone = 0, dcyc = 0;
    set_in(1'b0, 1'b1, 8'h3C, 8'h05, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3)      set_in(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
      else             set_in(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
      if (done8) begin ndone++; got = {c8, r8}; dcyc = k; end
    end
    n_cmp++;
    if (ndone !== 1) begin n_fail++; $display("FAIL ignore_count: done pulses=%0d required 1", ndone); end
    n_cmp++;
    if (got !== ex) begin n_fail++; $display("FAIL ignore_result: got %h required %h", got, ex); end
    n_cmp++;
    if (dcyc !== 9) begin n_fail++; $display("FAIL ignore_latency: done at cycle %0d required 9", dcyc); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r; logic c, da; int nb; bit to; int ndone = 0;
    logic [8:0] ex = model(8, 'h9A, 'h7B, 1'b0);
    do_op(1'b0, 8'h3C, 8'h05, 1'b0, r, c, nb, to, da);  // leaves a nonzero result
    set_in(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy8, done8, r8, c8} !== 11'h0) begin
      n_fail++; $display("FAIL reset_mid: busy/done/result/cout=%b/%b/%h/%b required 0/0/00/0", busy8, done8, r8, c8);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin n_fail++; $display("FAIL reset_mid_nodone: done pulses=%0d required 0", ndone); end
    do_op(1'b0, 8'h9A, 8'h7B, 1'b0, r, c, nb, to, da);
    n_cmp++;
    if (to || {c, r} !== ex) begin
      n_fail++; $display("FAIL reset_mid_fresh: got cout=%b result=%h required cout=%b result=%h", c, r, ex[8], ex[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [3]; logic [7:0] ob [3]; bit om [3]; logic [8:0] ex [3]; int td [3];
    int k = 0, cyc = 0; bit pend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      oa[i] = 8'($urandom); ob[i] = 8'($urandom); om[i] = 1'(i);
      ex[i] = model(8, int'(oa[i]), int'(ob[i]), om[i]);
      td[i] = 0;
    end
    set_in(1'b0, 1'b1, oa[0], ob[0], om[0]);
    @(negedge clk);
    set_in(1'b0, 1'b1, oa[1], ob[1], om[1]);
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (pend) begin set_in(1'b0, 1'b1, oa[2], ob[2], om[2]); pend = 1'b0; end
      if (done8) begin
        n_cmp++;
        if ({c8, r8} !== ex[k]) begin
          n_fail++; $display("FAIL b2b_result[%0d]: got %h required %h", k, {c8, r8}, ex[k]);
        end
        td[k] = cyc;
        if (k == 0) pend = 1'b1;
        if (k == 2) set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        k++;
      end
    end
    n_cmp++;
    if (k !== 3) begin n_fail++; $display("FAIL b2b_timeout: completions=%0d required 3", k); end
    n_cmp++;
    if (td[1] - td[0] !== 9 || td[2] - td[1] !== 9) begin
      n_fail++; $display("FAIL b2b_spacing: gaps=%0d,%0d required 9,9", td[1] - td[0], td[2] - td[1]);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy8, done8} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_idle: busy/done=%b/%b required 0/0", busy8, done8);
    end
  endtask

  task automatic test_exhaustive4();
    logic [7:0] r; logic c, da; int nb; bit to; logic [8:0] ex;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          ex = model(4, a, b, 1'(m));
          do_op(1'b1, 8'(a), 8'(b), 1'(m), r, c, nb, to, da);
          n_cmp++;
          if (to || nb != 4 || {c, r} !== ex) begin
            n_fail++; $display("FAIL w4 %0d %s %0d: got cout=%b result=%h busy=%0d timeout=%b required cout=%b result=%h busy=4",
                               a, m ? "-" : "+", b, c, r, nb, to, ex[8], ex[7:0]);
          end
        end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random8();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
